// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin channel multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, evaluated at elaboration to size channel indices.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester above ptr, wrapping to 0.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int CW       = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CW-1:0]       ptr,
    output logic                gnt_valid,
    output logic [CW-1:0]       gnt_idx
);

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Scan farthest-first so the nearest requester after ptr is written last and wins.
        for (int k = CHANNELS; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % CHANNELS;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// Channel multiplexer with fixed-select or round-robin grant into a one-entry output register.
module rr_mux_arb
    import mux_pkg::*;
#(
    parameter  int WIDTH     = 5,
    parameter  int OUT_WIDTH = 32,
    parameter  int CHANNELS  = 4,
    localparam int CW        = clog2(CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      mode,
    input  logic [CW-1:0]             sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic [CW-1:0]             out_chan
);

    logic [CW-1:0]    ptr;
    logic             rr_valid;
    logic [CW-1:0]    rr_idx;
    logic             fixed_valid;
    logic             gnt_valid;
    logic [CW-1:0]    gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load_en;
    logic             transfer;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Loop compare rather than in_valid[sel] so an out-of-range sel simply finds nothing.
    always_comb begin
        fixed_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == CW'(i)) fixed_valid = in_valid[i];
        end
    end

    assign gnt_valid = (mode == MODE_RR) ? rr_valid : fixed_valid;
    assign gnt_idx   = (mode == MODE_RR) ? rr_idx   : sel;
    assign gnt_data  = in_data[gnt_idx*WIDTH +: WIDTH];
    assign load_en   = !out_valid || out_ready;
    assign transfer  = Reset && load_en && gnt_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = transfer && (gnt_idx == CW'(i));
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!Reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= CW'(CHANNELS - 1);
        end else if (load_en) begin
            out_valid <= gnt_valid;
            if (gnt_valid) begin
                out_data <= OUT_WIDTH'(gnt_data);
                out_chan <= gnt_idx;
                if (mode == MODE_RR) ptr <= gnt_idx;
            end
        end
    end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, input channel data width.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 32, output data width, constrained OUT_WIDTH >= WIDTH.
REQ-003 The block SHALL have parameter CHANNELS, default 4, number of input channels, constrained 2..16.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Reset  input  1  reset, synchronous, active-low.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-007 sel  input  CW  channel index used in mode 0, where CW = clog2(CHANNELS).
REQ-008 in_valid  input  CHANNELS  per-channel data-valid.
REQ-009 in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  CHANNELS  per-channel accept strobe.
REQ-011 out_valid  output  1  output register holds valid data.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  OUT_WIDTH  selected data, zero-extended.
REQ-014 out_chan  output  CW  index of the channel that supplied out_data.

Function
REQ-015 The block SHALL implement a single-entry output register with load_en = !out_valid || out_ready.
REQ-016 In mode 0, grant SHALL be sel when in_valid[sel]=1; otherwise there is no grant.
REQ-017 In mode 1, grant SHALL be the first channel with in_valid set, searching upward from (ptr+1) mod CHANNELS and wrapping past CHANNELS-1 to 0.
REQ-018 in_ready[i] SHALL be 1 only when i is granted and load_en=1; at most one bit is high per cycle (one-hot or zero).
REQ-019 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i].
REQ-020 On a transfer, the next edge SHALL load out_data = zero-extended in_data[i], out_chan = i, out_valid = 1.
REQ-021 Latency from input transfer to out_valid SHALL be exactly 1 cycle; throughput SHALL be 1 transfer/cycle while out_ready=1.
REQ-022 When load_en=1 and there is no grant, out_valid SHALL clear on the next edge; out_data and out_chan SHALL hold.
REQ-023 While out_valid=1 && out_ready=0, out_data and out_chan SHALL hold regardless of changes to sel, mode or in_data.
REQ-024 ptr SHALL update to i only on a transfer in mode 1; transfers in mode 0 and idle cycles SHALL leave ptr unchanged.
REQ-025 A change of mode or sel SHALL take effect in the same cycle's grant; no pipeline flush is needed.
REQ-026 If sel >= CHANNELS, the block SHALL produce no grant.
REQ-027 A simultaneous downstream pop and upstream push in the same cycle SHALL be legal and lossless.

Reset
REQ-028 When Reset=0 at a rising edge, the block SHALL set out_valid=0, out_data=0, out_chan=0 and ptr=CHANNELS-1, so that channel 0 has highest priority after reset.
REQ-029 While Reset=0, in_ready SHALL be all-zero.
REQ-030 A reset asserted mid-transfer SHALL discard the held entry, with no partial output.

Structure
REQ-031 The shared package mux_pkg SHALL hold the MODE_FIXED/MODE_RR constants and the clog2 helper function.
REQ-032 The round-robin priority search SHALL be a sub-module named rr_arbiter with ports req, ptr, gnt_valid and gnt_idx; it SHALL be purely combinational.
REQ-033 The output register and ptr SHALL reside in rr_mux_arb.

Verification
REQ-034 Reset: hold Reset=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0; first grant in mode 1 goes to channel 0.
REQ-035 Mode 0: set sel=2, in_valid=4'b1111, in_data[2]=5'h1F, out_ready=1 -> the next cycle shows out_data=32'h0000001F, out_chan=2; in_ready=4'b0100 in the cycle of the transfer.
REQ-036 Mode 1 fairness: hold in_valid=4'b1111 and out_ready=1 for 8 cycles -> out_chan sequence is 0,1,2,3,0,1,2,3.
REQ-037 Stall: out_valid=1, out_ready=0 for 3 cycles while sel and in_data change -> out_data stable and in_ready=0; releasing out_ready gives a same-cycle pop plus push.
REQ-038 Wrap and skip: ptr=3, in_valid=4'b0100 -> grant channel 2; next with in_valid=4'b0011 -> grant channel 0.
REQ-039 Reset mid-operation: assert Reset=0 while out_valid=1 -> out_valid=0 at the next edge; ptr returns to CHANNELS-1.
